// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: holds the decode-stage control groups and operands for one cycle.
// Optional bubble input `flush` exists only when ID_EX_FLUSH_EN is defined.
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int WB_W   = 2,
    parameter int M_W    = 3,
    parameter int EX_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
`ifdef ID_EX_FLUSH_EN
    input  logic              flush,
`endif
    input  logic [WB_W-1:0]   ctlwb_out,
    input  logic [M_W-1:0]    ctlm_out,
    input  logic [EX_W-1:0]   ctlex_out,
    input  logic [DATA_W-1:0] npc,
    input  logic [DATA_W-1:0] readdat1,
    input  logic [DATA_W-1:0] readdat2,
    input  logic [DATA_W-1:0] signext_out,
    input  logic [REG_W-1:0]  instr_2016,
    input  logic [REG_W-1:0]  instr_1511,
    output logic [WB_W-1:0]   wb_ctlout,
    output logic [M_W-1:0]    m_ctlout,
    output logic [EX_W-1:0]   ex_ctlout,
    output logic [DATA_W-1:0] npcout,
    output logic [DATA_W-1:0] rdata1out,
    output logic [DATA_W-1:0] rdata2out,
    output logic [DATA_W-1:0] s_extendout,
    output logic [REG_W-1:0]  instrout_2016,
    output logic [REG_W-1:0]  instrout_1511
);

    // Bubble request: zeroing only the control groups turns the instruction into a NOP
    // while the operand fields still advance.
    logic bubble;

`ifdef ID_EX_FLUSH_EN
    assign bubble = flush;
`else
    assign bubble = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values; the async reset clears the whole stage to a NOP bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ctlout <= '0;
            m_ctlout  <= '0;
            ex_ctlout <= '0;
        end else if (bubble) begin
            wb_ctlout <= '0;
            m_ctlout  <= '0;
            ex_ctlout <= '0;
        end else begin
            wb_ctlout <= ctlwb_out;
            m_ctlout  <= ctlm_out;
            ex_ctlout <= ctlex_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            npcout        <= '0;
            rdata1out     <= '0;
            rdata2out     <= '0;
            s_extendout   <= '0;
            instrout_2016 <= '0;
            instrout_1511 <= '0;
        end else begin
            npcout        <= npc;
            rdata1out     <= readdat1;
            rdata2out     <= readdat2;
            s_extendout   <= signext_out;
            instrout_2016 <= instr_2016;
            instrout_1511 <= instr_1511;
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: a queue of expected stage contents is filled when
// inputs are driven and drained one entry per rising edge.
module tb_id_ex_pipe_reg;

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  ex;
        logic [31:0] npc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] sext;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } bundle_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [1:0]  ctlwb_out;
    logic [2:0]  ctlm_out;
    logic [3:0]  ctlex_out;
    logic [31:0] npc, readdat1, readdat2, signext_out;
    logic [4:0]  instr_2016, instr_1511;
    logic [1:0]  wb_ctlout;
    logic [2:0]  m_ctlout;
    logic [3:0]  ex_ctlout;
    logic [31:0] npcout, rdata1out, rdata2out, s_extendout;
    logic [4:0]  instrout_2016, instrout_1511;

    int checks   = 0;
    int failures = 0;
    bundle_t exp_q[$];
    bundle_t held;

    id_ex_pipe_reg dut (
        .clk           (clk),
        .rst           (rst),
`ifdef ID_EX_FLUSH_EN
        .flush         (flush),
`endif
        .ctlwb_out     (ctlwb_out),
        .ctlm_out      (ctlm_out),
        .ctlex_out     (ctlex_out),
        .npc           (npc),
        .readdat1      (readdat1),
        .readdat2      (readdat2),
        .signext_out   (signext_out),
        .instr_2016    (instr_2016),
        .instr_1511    (instr_1511),
        .wb_ctlout     (wb_ctlout),
        .m_ctlout      (m_ctlout),
        .ex_ctlout     (ex_ctlout),
        .npcout        (npcout),
        .rdata1out     (rdata1out),
        .rdata2out     (rdata2out),
        .s_extendout   (s_extendout),
        .instrout_2016 (instrout_2016),
        .instrout_1511 (instrout_1511)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic bundle_t observed();
        bundle_t o;
        o.wb   = wb_ctlout;
        o.m    = m_ctlout;
        o.ex   = ex_ctlout;
        o.npc  = npcout;
        o.rd1  = rdata1out;
        o.rd2  = rdata2out;
        o.sext = s_extendout;
        o.rt   = instrout_2016;
        o.rd   = instrout_1511;
        return o;
    endfunction

    function automatic bundle_t mk(input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                                   input logic [31:0] n, input logic [31:0] r1, input logic [31:0] r2,
                                   input logic [31:0] s, input logic [4:0] rt, input logic [4:0] rd);
        bundle_t b;
        b.wb = wb; b.m = m; b.ex = ex; b.npc = n; b.rd1 = r1; b.rd2 = r2;
        b.sext = s; b.rt = rt; b.rd = rd;
        return b;
    endfunction

    task automatic check(input string tag, input bundle_t expv);
        bundle_t obs;
        obs = observed();
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one set of ID outputs and record what EX must see after the next edge.
    task automatic drive(input bundle_t b, input logic fl);
        bundle_t e;
        ctlwb_out = b.wb; ctlm_out = b.m; ctlex_out = b.ex;
        npc = b.npc; readdat1 = b.rd1; readdat2 = b.rd2; signext_out = b.sext;
        instr_2016 = b.rt; instr_1511 = b.rd;
        flush = fl;
        e = b;
`ifdef ID_EX_FLUSH_EN
        if (fl) begin
            e.wb = '0; e.m = '0; e.ex = '0;
        end
`endif
        exp_q.push_back(e);
    endtask

    task automatic edge_and_check(input string tag);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            held = exp_q.pop_front();
            check(tag, held);
        end
    endtask

    initial begin
        bundle_t zero, s2, s4, ones, r;
        zero = '0;
        s2   = mk(2'd1, 3'd1, 4'd2, 32'd10, 32'd15, 32'd20, 32'd20, 5'd2, 5'd2);
        s4   = mk(2'd2, 3'd2, 4'd1, 32'd5, 32'd10, 32'd25, 32'd23, 5'd1, 5'd3);
        ones = '1;
        flush = 1'b0;

        // Reset with garbage on the inputs; outputs clear at once and stay clear.
        rst = 1'b1;
        ctlwb_out = 2'h3; ctlm_out = 3'h7; ctlex_out = 4'hf;
        npc = 32'hdead_beef; readdat1 = 32'h1234_5678; readdat2 = 32'h8765_4321;
        signext_out = 32'hffff_8000; instr_2016 = 5'h1f; instr_1511 = 5'h15;
        #1;
        check("reset_immediate", zero);
        repeat (2) begin
            @(posedge clk); #1;
            check("reset_hold_clk", zero);
        end

        // Scenario 2: capture exactly one edge later, not before.
        @(negedge clk);
        rst = 1'b0;
        drive(s2, 1'b0);
        #1;
        check("s2_not_before_edge", zero);
        edge_and_check("s2_capture");

        // Reset asserted between edges clears without a clock edge.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midcycle_reset", zero);
        @(posedge clk); #1;
        check("midcycle_reset_over_edge", zero);

        // Scenario 4 after reset release.
        @(negedge clk);
        rst = 1'b0;
        drive(s4, 1'b0);
        edge_and_check("s4_capture");

        // Mid-cycle input changes are invisible until the next edge.
        @(negedge clk);
        drive(s2, 1'b0);
        #1;
        check("s4_hold_after_change", s4);
        ctlwb_out = 2'd3; npc = 32'd99; readdat1 = 32'd77;
        exp_q[0].wb = 2'd3; exp_q[0].npc = 32'd99; exp_q[0].rd1 = 32'd77;
        #2;
        check("s4_hold_second_change", s4);
        edge_and_check("late_change_capture");

        // Full-width values pass through without truncation.
        @(negedge clk);
        drive(ones, 1'b0);
        edge_and_check("all_ones");

        // Pending capture overridden by a reset pulse; the next clean edge loads normally.
        @(negedge clk);
        drive(s2, 1'b0);
        void'(exp_q.pop_back());
        rst = 1'b1;
        #1;
        check("pulse_reset_clears", zero);
        rst = 1'b0;
        exp_q.push_back(s2);
        edge_and_check("release_first_edge");

        // Back-to-back random traffic.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            r = mk(2'($urandom), 3'($urandom), 4'($urandom), $urandom, $urandom,
                   $urandom, $urandom, 5'($urandom), 5'($urandom));
            drive(r, 1'b0);
            edge_and_check("random_stream");
        end

`ifdef ID_EX_FLUSH_EN
        // Bubble: control cleared, operands still advance.
        @(negedge clk);
        drive(s2, 1'b1);
        edge_and_check("flush_bubble");
        @(negedge clk);
        drive(s4, 1'b0);
        edge_and_check("after_flush");
        // Reset wins over flush.
        @(negedge clk);
        drive(s2, 1'b1);
        void'(exp_q.pop_back());
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_over_flush", zero);
        rst = 1'b0;
        flush = 1'b0;
`endif

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
